// File: rtl/instr_ram_pkg.sv
// Shared types and constants for the instruction RAM slice.
//   mode_e          : operating mode encoding on the MODE bus
//   DELIM / IDLE    : loader stream control bytes
//   DEF_ADDR_WIDTH  : default address (and data) width
//   DEF_MAX_ADDRESS : default highest usable address
package instr_ram_pkg;

  localparam int unsigned DEF_ADDR_WIDTH  = 8;
  localparam int unsigned DEF_MAX_ADDRESS = 255;

  localparam logic [7:0] DELIM = 8'h24;
  localparam logic [7:0] IDLE  = 8'h00;

  typedef enum logic [1:0] {
    MODE_LOAD  = 2'd0,
    MODE_STEP  = 2'd1,
    MODE_FETCH = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

endpackage

// File: rtl/instruction_ram_if.sv
// Loader / debug / CPU access bus of the instruction RAM.
//   DEBUG    : step button level (STEP mode)
//   MODE     : mode select, see instr_ram_pkg::mode_e
//   address  : CPU read address (FETCH mode)
//   data_in  : loader byte stream (LOAD mode)
//   data_out : read data, combinational from the RAM side
interface instruction_ram_if #(
  parameter int unsigned ADDR_WIDTH = instr_ram_pkg::DEF_ADDR_WIDTH
);

  logic                  DEBUG;
  logic [1:0]            MODE;
  logic [ADDR_WIDTH-1:0] address;
  logic [ADDR_WIDTH-1:0] data_in;
  logic [ADDR_WIDTH-1:0] data_out;

  modport master (
    output DEBUG,
    output MODE,
    output address,
    output data_in,
    input  data_out
  );

  modport slave (
    input  DEBUG,
    input  MODE,
    input  address,
    input  data_in,
    output data_out
  );

endinterface

// File: rtl/instr_ram_mem.sv
// Storage array of the instruction RAM: synchronous write, asynchronous read.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, combinational from raddr
module instr_ram_mem #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [ADDR_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH-1:0] rdata
);

  logic [ADDR_WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset; a reset only clears the loader pointers.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_ram.sv
// Byte-wide program RAM between the serial loader and the CPU core.
//   clk : system clock, all state on posedge
//   rst : synchronous active-high reset
//   bus : instruction_ram_if slave (DEBUG, MODE, address, data_in -> data_out)
// LOAD captures a '$'-delimited level-held byte stream, STEP walks the stored
// bytes with the debug button, FETCH gives the CPU random read access.
module instruction_ram
  import instr_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned MAX_ADDRESS = DEF_MAX_ADDRESS
) (
  input  logic               clk,
  input  logic               rst,
  instruction_ram_if.slave   bus
);

  localparam int unsigned CW    = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = MAX_ADDRESS + 1;

  logic [ADDR_WIDTH-1:0] wr_ptr_q,     wr_ptr_d;
  logic [CW-1:0]         count_q,      count_d;
  logic [ADDR_WIDTH-1:0] step_ptr_q,   step_ptr_d;
  logic [ADDR_WIDTH-1:0] prev_data_q,  prev_data_d;
  logic                  prev_debug_q, prev_debug_d;

  mode_e                 mode;
  logic                  data_event;
  logic                  has_room;
  logic                  debug_rise;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [ADDR_WIDTH-1:0] rdata;

  // Next-state logic for loader pointers, step pointer and edge detectors.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    step_ptr_d   = '0;
    prev_data_d  = bus.data_in;
    prev_debug_d = bus.DEBUG;
    mem_we       = 1'b0;

    mode       = mode_e'(bus.MODE);
    data_event = (bus.data_in != prev_data_q);
    has_room   = (count_q <= CW'(MAX_ADDRESS));
    debug_rise = bus.DEBUG & ~prev_debug_q;

    case (mode)
      MODE_LOAD: begin
        // Once count reaches DEPTH the loader saturates: no more writes or commits.
        if (data_event && has_room) begin
          if (bus.data_in == ADDR_WIDTH'(DELIM)) begin
            count_d  = count_q + CW'(1);
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
          end else if (bus.data_in != ADDR_WIDTH'(IDLE)) begin
            mem_we = ~rst;
          end
        end
      end
      MODE_STEP: begin
        step_ptr_d = step_ptr_q;
        // Advance only while a later committed byte exists; otherwise hold at the last one.
        if (debug_rise && (count_q != '0) &&
            ({1'b0, step_ptr_q} < (count_q - CW'(1)))) begin
          step_ptr_d = step_ptr_q + ADDR_WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      count_q      <= '0;
      step_ptr_q   <= '0;
      prev_data_q  <= '0;
      prev_debug_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      step_ptr_q   <= step_ptr_d;
      prev_data_q  <= prev_data_d;
      prev_debug_q <= prev_debug_d;
    end
  end

  assign raddr = (mode == MODE_STEP) ? step_ptr_q : bus.address;

  instr_ram_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (bus.data_in),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Output mux: only STEP and FETCH expose memory contents.
  always_comb begin
    bus.data_out = '0;
    if (!rst && ((mode == MODE_STEP) || (mode == MODE_FETCH))) begin
      bus.data_out = rdata;
    end
  end

endmodule

// File: tb/tb_instruction_ram.sv
// Self-checking bench for instruction_ram: directed vector table, multi-cycle
// sequences, and randomized traffic against a behavioural model.
module tb_instruction_ram;
  import instr_ram_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruction_ram_if #(.ADDR_WIDTH(8)) bus();

  instruction_ram dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        r;
    logic [1:0]  m;
    logic        d;
    logic [7:0]  a;
    logic [7:0]  din;
    logic [7:0]  exp;
    logic [63:0] tag;
  } vec_t;

  vec_t vq[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Behavioural model: memory with known-content flags plus loader/step bookkeeping.
  logic [7:0] m_mem [256];
  bit         m_val [256];
  int         m_count, m_wr, m_step;
  logic [7:0] m_pdata;
  logic       m_pdbg;

  task automatic model_reset();
    m_count = 0; m_wr = 0; m_step = 0; m_pdata = 8'h00; m_pdbg = 1'b0;
  endtask

  task automatic model_out(input logic r, input logic [1:0] m, input logic [7:0] a,
                           output logic [7:0] e, output bit known);
    e = 8'h00; known = 1'b1;
    if (!r) begin
      if (m == 2'd1) begin
        e = m_mem[m_step]; known = m_val[m_step];
      end else if (m == 2'd2) begin
        e = m_mem[a]; known = m_val[a];
      end
    end
  endtask

  task automatic model_step(input logic r, input logic [1:0] m, input logic d, input logic [7:0] din);
    if (r) begin
      model_reset();
      return;
    end
    if (m == 2'd0 && din != m_pdata) begin
      if (din == 8'h24) begin
        if (m_count < 256) begin
          m_count++;
          m_wr = (m_wr + 1) % 256;
        end
      end else if (din != 8'h00 && m_count < 256) begin
        m_mem[m_wr] = din;
        m_val[m_wr] = 1'b1;
      end
    end
    if (m == 2'd1) begin
      if (d && !m_pdbg && m_count > 0 && m_step < m_count - 1) m_step++;
    end else begin
      m_step = 0;
    end
    m_pdata = din;
    m_pdbg  = d;
  endtask

  task automatic check(input logic [63:0] tag, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: data_out=%h expected %h", tag, act, exp);
  endtask

  // One clock: drive, sample at negedge, then advance the model at posedge.
  task automatic run_cycle(input logic r, input logic [1:0] m, input logic d, input logic [7:0] a,
                           input logic [7:0] din, output logic [7:0] act,
                           output logic [7:0] mexp, output bit known);
    rst = r; bus.MODE = m; bus.DEBUG = d; bus.address = a; bus.data_in = din;
    @(negedge clk);
    act = bus.data_out;
    model_out(r, m, a, mexp, known);
    @(posedge clk);
    model_step(r, m, d, din);
    #1;
  endtask

  task automatic model_cycle(input logic r, input logic [1:0] m, input logic d, input logic [7:0] a,
                             input logic [7:0] din, input logic [63:0] tag);
    logic [7:0] act, mexp;
    bit known;
    run_cycle(r, m, d, a, din, act, mexp, known);
    if (known) check(tag, act, mexp);
  endtask

  task automatic add(input logic r, input logic [1:0] m, input logic d, input logic [7:0] a,
                     input logic [7:0] din, input logic [7:0] exp, input logic [63:0] tag);
    vec_t v;
    v.r = r; v.m = m; v.d = d; v.a = a; v.din = din; v.exp = exp; v.tag = tag;
    vq.push_back(v);
  endtask

  initial begin
    logic [7:0] stream [8];
    logic [7:0] bytes4 [4];
    logic [7:0] act, mexp, din_cur;
    bit known;

    for (int i = 0; i < 256; i++) begin m_mem[i] = 8'h00; m_val[i] = 1'b0; end
    model_reset();
    rst = 1'b1; bus.MODE = 2'd0; bus.DEBUG = 1'b0; bus.address = 8'h00; bus.data_in = 8'h00;
    @(posedge clk); #1;

    stream = '{8'h4A, 8'h24, 8'h4B, 8'h24, 8'h4C, 8'h24, 8'h4D, 8'h24};
    bytes4 = '{8'h4A, 8'h4B, 8'h4C, 8'h4D};

    // Reset and idle
    add(1, 0, 0, 8'h00, 8'h00, 8'h00, "rst_out");
    add(1, 0, 0, 8'h00, 8'h00, 8'h00, "rst_out");
    for (int i = 0; i < 4; i++) add(0, 0, 0, 8'h00, 8'h00, 8'h00, "idle");
    // Load four delimited bytes, each level held 4 cycles
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 4; k++) add(0, 0, 0, 8'h00, stream[i], 8'h00, "load_out");
    // Step through with 1-cycle pulses
    add(0, 1, 0, 8'h00, 8'h24, 8'h4A, "step0");
    for (int i = 1; i < 4; i++) begin
      add(0, 1, 1, 8'h00, 8'h24, bytes4[i-1], "step_pls");
      add(0, 1, 0, 8'h00, 8'h24, bytes4[i], "step");
    end
    // Saturation at the last committed byte
    for (int i = 0; i < 4; i++) begin
      add(0, 1, 1, 8'h00, 8'h24, 8'h4D, "step_sat");
      add(0, 1, 0, 8'h00, 8'h24, 8'h4D, "step_sat");
    end
    // Random-access fetch, then re-entry into STEP
    for (int i = 0; i < 4; i++) add(0, 2, 0, 8'(i), 8'h24, bytes4[i], "fetch");
    add(0, 3, 0, 8'h00, 8'h24, 8'h00, "rsvd");
    add(0, 1, 0, 8'h00, 8'h24, 8'h4A, "reenter");
    // Long press advances exactly once
    add(0, 1, 1, 8'h00, 8'h24, 8'h4A, "hold");
    for (int i = 0; i < 9; i++) add(0, 1, 1, 8'h00, 8'h24, 8'h4B, "hold");
    add(0, 1, 0, 8'h00, 8'h24, 8'h4B, "hold_rel");

    foreach (vq[i]) begin
      run_cycle(vq[i].r, vq[i].m, vq[i].d, vq[i].a, vq[i].din, act, mexp, known);
      check(vq[i].tag, act, vq[i].exp);
    end

    // Reset mid-load: earlier bytes survive, count restarts at 0
    model_cycle(1, 0, 0, 8'h00, 8'h00, "rst6");
    foreach (stream[i]) begin end
    model_cycle(0, 0, 0, 8'h00, 8'h11, "ml");
    model_cycle(0, 0, 0, 8'h00, 8'h24, "ml");
    model_cycle(0, 0, 0, 8'h00, 8'h22, "ml");
    model_cycle(0, 0, 0, 8'h00, 8'h24, "ml");
    model_cycle(0, 0, 0, 8'h00, 8'h33, "ml");
    run_cycle(1, 2, 0, 8'h00, 8'h00, act, mexp, known);
    check("rst_mask", act, 8'h00);
    run_cycle(1, 2, 0, 8'h00, 8'h00, act, mexp, known);
    check("rst_mask", act, 8'h00);
    model_cycle(0, 0, 0, 8'h00, 8'h55, "ml2");
    model_cycle(0, 0, 0, 8'h00, 8'h55, "ml2");
    model_cycle(0, 0, 0, 8'h00, 8'h24, "ml2");
    run_cycle(0, 1, 0, 8'h00, 8'h24, act, mexp, known);
    check("one_step", act, 8'h55);
    for (int i = 0; i < 3; i++) begin
      run_cycle(0, 1, 1, 8'h00, 8'h24, act, mexp, known);
      run_cycle(0, 1, 0, 8'h00, 8'h24, act, mexp, known);
      check("one_sat", act, 8'h55);
    end
    run_cycle(0, 2, 0, 8'h01, 8'h24, act, mexp, known);
    check("kept1", act, 8'h22);
    run_cycle(0, 2, 0, 8'h02, 8'h24, act, mexp, known);
    check("kept2", act, 8'h33);
    run_cycle(0, 2, 0, 8'h03, 8'h24, act, mexp, known);
    check("kept3", act, 8'h4D);

    // Fill past capacity: writes and commits must stop at 256 entries
    model_cycle(1, 0, 0, 8'h00, 8'h00, "ovf_rst");
    for (int i = 0; i < 300; i++) begin
      model_cycle(0, 0, 0, 8'h00, 8'(8'h30 + (i % 64)), "ovf_ld");
      model_cycle(0, 0, 0, 8'h00, 8'h24, "ovf_ld");
    end
    for (int i = 0; i < 256; i++) model_cycle(0, 2, 0, 8'(i), 8'h24, "ovf_rd");
    for (int i = 0; i < 260; i++) begin
      model_cycle(0, 1, 1, 8'h00, 8'h24, "ovf_st");
      model_cycle(0, 1, 0, 8'h00, 8'h24, "ovf_st");
    end

    // Randomized traffic against the model
    model_cycle(1, 0, 0, 8'h00, 8'h00, "rnd_rst");
    din_cur = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] m;
      logic       r;
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0:       din_cur = 8'h00;
          1:       din_cur = 8'h24;
          default: din_cur = 8'($urandom_range(0, 255));
        endcase
      end
      m = ($urandom_range(0, 9) < 5) ? 2'd0 : 2'($urandom_range(1, 3));
      r = ($urandom_range(0, 299) == 0);
      model_cycle(r, m, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), din_cur, "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
